// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-ported memory between the instruction
// cache and the vector data cache. Data has priority, but after each data
// burst a pending instruction read is guaranteed the next grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 17,
  parameter int LEN           = 32,
  parameter int VECTOR_SIZE   = 8,
  parameter int BEAT_CNT_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  output logic [LEN-1:0]           i_data,
  output logic                     i_ready,
  input  logic [1:0]               d_vis_signal,
  input  logic [ADDR_WIDTH-1:0]    d_addr,
  input  logic [LEN-1:0]           d_wdata,
  input  logic [BEAT_CNT_SIZE-1:0] d_write_length,
  output logic [LEN-1:0]           d_rdata,
  output logic [1:0]               mem_status,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic                     ram_we,
  output logic [LEN-1:0]           ram_wdata,
  input  logic [LEN-1:0]           ram_rdata
);

  // State encoding doubles as the broadcast memory status.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INST = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_RB    = 2'd3;

  localparam logic [BEAT_CNT_SIZE-1:0] BEAT_MAX = BEAT_CNT_SIZE'(VECTOR_SIZE);

  logic [1:0]               state_q, state_d;
  logic [BEAT_CNT_SIZE-1:0] beat_q, beat_d;
  logic                     inst_pref_q, inst_pref_d;
  logic [ADDR_WIDTH-1:0]    last_addr_q;
  logic [LEN-1:0]           i_data_q;
  logic [LEN-1:0]           d_rdata_q;

  logic                     d_serve;
  logic                     i_serve;
  logic [BEAT_CNT_SIZE-1:0] serve_beat;
  logic [BEAT_CNT_SIZE-1:0] len_eff;
  logic                     d_cmd;
  logic                     burst_cmd;
  logic                     d_win_idle;

  assign d_cmd      = (d_vis_signal != CMD_NOP);
  assign burst_cmd  = (d_vis_signal == CMD_RB) || (d_vis_signal == CMD_WRITE);
  // A pending instruction read that waited out a burst beats any new data request.
  assign d_win_idle = d_cmd && !(inst_pref_q && i_req);
  assign len_eff    = (d_write_length > BEAT_MAX) ? BEAT_MAX : d_write_length;

  // State register plus the held read data and last presented address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      inst_pref_q <= 1'b0;
      last_addr_q <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      inst_pref_q <= inst_pref_d;
      if (d_serve || i_serve) last_addr_q <= ram_addr;
      if (i_serve) i_data_q  <= ram_rdata;
      if (d_serve) d_rdata_q <= ram_rdata;
    end
  end

  // Next-state, beat counter and fairness flag.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    inst_pref_d = inst_pref_q;
    case (state_q)
      ST_IDLE: begin
        if (d_win_idle) begin
          state_d = ST_DATA;
          beat_d  = BEAT_CNT_SIZE'(1);
        end else if (i_req) begin
          state_d     = ST_INST;
          inst_pref_d = 1'b0;
        end
      end
      ST_INST: state_d = ST_IDLE;
      ST_DATA: begin
        if (beat_q == BEAT_MAX || !d_cmd) begin
          state_d     = ST_IDLE;
          beat_d      = '0;
          inst_pref_d = i_req;
        end else if (burst_cmd) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Which requester owns the memory this cycle, and the resulting memory drive.
  always_comb begin
    d_serve    = 1'b0;
    i_serve    = 1'b0;
    serve_beat = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (d_win_idle) begin
          d_serve    = 1'b1;
          serve_beat = '0;
        end else if (i_req) begin
          i_serve = 1'b1;
        end
      end
      ST_DATA: d_serve = (beat_q != BEAT_MAX) && burst_cmd;
      default: ;
    endcase
    // Reset silences the memory immediately, even with a command still asserted.
    if (rst) begin
      d_serve = 1'b0;
      i_serve = 1'b0;
    end
    if (d_serve)      ram_addr = d_addr + (ADDR_WIDTH'(serve_beat) << 2);
    else if (i_serve) ram_addr = i_addr;
    else              ram_addr = last_addr_q;
    ram_we    = d_serve && (d_vis_signal == CMD_WRITE) && (serve_beat < len_eff);
    ram_wdata = d_wdata;
    i_ready   = i_serve;
    i_data    = i_serve ? ram_rdata : i_data_q;
    d_rdata   = d_serve ? ram_rdata : d_rdata_q;
  end

  assign mem_status = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction cache, the vector data cache and a single-ported main memory.
- Arbitrates access: data cache has priority; the instruction cache gets one guaranteed grant after each data burst.
- Generates the per-beat burst address for data read-burst/write sequences.
- Broadcasts the registered memory status that both caches poll before issuing requests.

Parameters:
ADDR_WIDTH, 17, byte address width
LEN, 32, word width in bits
VECTOR_SIZE, 8, maximum beats per data burst
BEAT_CNT_SIZE, 4, width of beat counter and write length (holds 0..VECTOR_SIZE)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
i_req  input  1  instruction read request, held until i_ready
i_addr  input  ADDR_WIDTH  instruction byte address
i_data  output  LEN  instruction word, valid when i_ready=1
i_ready  output  1  one-cycle pulse, instruction read served this cycle
d_vis_signal  input  2  data cache command: 0 NOP, 1 READ, 2 WRITE, 3 READ_BURST
d_addr  input  ADDR_WIDTH  data burst start byte address (held for the whole burst)
d_wdata  input  LEN  current write beat data
d_write_length  input  BEAT_CNT_SIZE  number of valid write beats in this burst
d_rdata  output  LEN  current read beat data
mem_status  output  2  0 RESTING, 1 INST_WORKING, 2 DATA_WORKING
ram_addr  output  ADDR_WIDTH  memory byte address (combinational)
ram_we  output  1  memory write enable (combinational)
ram_wdata  output  LEN  memory write data
ram_rdata  input  LEN  asynchronous-read memory data for ram_addr

Behaviour:
- Reset (async, any cycle, including mid-burst): state=IDLE, beat=0, inst_pref=0, mem_status=0. Outputs: i_ready=0, ram_we=0, i_data/d_rdata=0, ram_addr=0. Any burst in flight is abandoned; there is no partial-write recovery.
- Memory reads are combinational: d_rdata/i_data = ram_rdata in the same cycle the access is presented, so the requester captures on the next edge.
- States and mem_status:
  - IDLE(0) drives RESTING.
  - INST(1) drives INST_WORKING.
  - DATA(2) drives DATA_WORKING.
  - mem_status is registered and equals the state encoding.
- IDLE, per cycle:
  - If d_vis_signal!=NOP and not (inst_pref and i_req): serve data beat 0 this cycle (address d_addr); next state DATA, beat<=1.
  - Else if i_req: ram_addr=i_addr, i_ready=1, inst_pref<=0; next state INST.
  - Else stay IDLE.
- INST: lasts exactly one cycle (ram idle, i_ready=0), then returns to IDLE. This gives the data cache a RESTING window.
- DATA, per cycle:
  - If d_vis_signal is READ_BURST or WRITE: serve beat at address d_addr + 4*beat (modulo 2^ADDR_WIDTH), then beat<=beat+1.
  - If d_vis_signal==NOP, or beat==VECTOR_SIZE: no access; next state IDLE, beat<=0; inst_pref<=i_req.
- READ (single-beat): served like beat 0, then DATA; terminates on the following NOP.
- Writes: ram_we=1 only when command is WRITE and the served beat index < d_write_length. Beats at or beyond the length are accepted and counted but not written. d_write_length=0 writes nothing. Values > VECTOR_SIZE are clamped to VECTOR_SIZE. ram_wdata=d_wdata.
- Fairness: inst_pref, once set, blocks a new data grant in IDLE until the instruction read has been served.
- Simultaneous i_req and d request in IDLE with inst_pref=0: data wins; i_ready=0; i_req stays pending.
- Whenever the instruction cache is not served, i_ready=0 and i_data holds its last value.
- Instruction requests during DATA stall; i_ready stays 0.
- ram_addr when idle = last served address (no spurious writes, since ram_we=0).

Test Plan:
- Read burst: d_addr=0x100, READ_BURST for 8 cycles, then NOP. Expect ram_addr 0x100,0x104..0x11C; d_rdata matches preloaded words; mem_status=2 from cycle 2; IDLE after the NOP.
- Write length 3: WRITE burst, d_addr=0x40, d_write_length=3, data A..H. Expect ram_we high only on beats 0-2; memory 0x40/0x44/0x48 = A/B/C; 0x4C unchanged.
- Contention: i_req and READ_BURST raised in the same IDLE cycle. Expect data granted first, i_ready=0 during the burst; after the burst, i_ready pulses once with i_addr's word, before any new data grant even if d_vis_signal=READ_BURST again.
- Overflow guard: keep READ_BURST asserted for 10 cycles. Expect exactly 8 addressed beats; state returns to IDLE after beat 7; beat counter resets.
- Address wrap: d_addr=0x1FFF8, 4-beat read. Expect addresses 0x1FFF8, 0x1FFFC, 0x00000, 0x00004.
- Async reset mid-write-burst (beat 3): expect mem_status=0 and ram_we=0 immediately without a clock edge; the next request starts at beat 0.
